// File: rtl/debounce_counter.sv
// N-channel debouncer: a synchroniser per input, a shared sample-tick prescaler, and a per-channel
// stability counter. The clean level follows only after STABLE_TICKS agreeing ticks.
module debounce_counter #(
  parameter int N            = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter int TICK_DIV     = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [SYNC_STAGES-1:0][N-1:0] r_sync;
  logic [DIV_W-1:0]              r_div;
  logic [N-1:0][CNT_W-1:0]       r_cnt;
  logic [N-1:0]                  r_out;
  logic [N-1:0]                  r_rise;
  logic [N-1:0]                  r_fall;

  logic                          w_tick;
  logic [N-1:0]                  w_syn;
  logic [N-1:0][CNT_W-1:0]       w_cnt_nxt;
  logic [N-1:0]                  w_out_nxt;
  logic [N-1:0]                  w_rise_nxt;
  logic [N-1:0]                  w_fall_nxt;

  assign w_syn  = r_sync[SYNC_STAGES-1];
  assign w_tick = en & (r_div == DIV_LAST);

  // The synchroniser keeps sampling while disabled so the level is current when en returns.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_out_nxt  = r_out;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (w_syn[i] == r_out[i]) begin
          // Any bounce back to the accepted level restarts the qualification.
          w_cnt_nxt[i] = '0;
        end else if (w_tick) begin
          if (r_cnt[i] == CNT_LAST) begin
            w_out_nxt[i]  = w_syn[i];
            w_cnt_nxt[i]  = '0;
            w_rise_nxt[i] = w_syn[i];
            w_fall_nxt[i] = ~w_syn[i];
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_cnt  <= '0;
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_out  <= w_out_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign out  = r_out;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule
